// File: rtl/console_cmd_parser_pkg.sv
// Shared types and ASCII constants for the UART console command parser.
package console_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StOp,
      StAddr,
      StData,
      StSkip,
      StPend
   } state_e;

   localparam logic [7:0] AsciiCr = 8'h0D;
   localparam logic [7:0] AsciiLf = 8'h0A;
   localparam logic [7:0] AsciiSp = 8'h20;
   localparam logic [7:0] AsciiRUp = 8'h52;
   localparam logic [7:0] AsciiRLo = 8'h72;
   localparam logic [7:0] AsciiWUp = 8'h57;
   localparam logic [7:0] AsciiWLo = 8'h77;

   function automatic logic is_hex_char(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) ||
             (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
   endfunction

endpackage

// File: rtl/console_cmd_parser_if.sv
// Receive-byte stream in, command handshake out; master side is the parser.
interface console_cmd_parser_if #(
   parameter int unsigned ADDR_DIGITS = 4,
   parameter int unsigned DATA_DIGITS = 2
);

   logic [7:0]               rx_data;
   logic                     rx_valid;
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_write;
   logic [4*ADDR_DIGITS-1:0] cmd_addr;
   logic [4*DATA_DIGITS-1:0] cmd_wdata;
   logic                     cmd_error;
   logic                     rx_dropped;

   modport master (
      input  rx_data, rx_valid, cmd_ready,
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_error, rx_dropped
   );

   modport slave (
      output rx_data, rx_valid, cmd_ready,
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_error, rx_dropped
   );

endinterface

// File: rtl/console_cmd_parser_ascii_to_hex.sv
// Combinational ASCII hex character to nibble decoder; non-hex input yields 0.
module ascii_to_hex (
   input  logic [7:0] char_i,
   output logic [3:0] nibble_o
);

   always_comb begin
      nibble_o = 4'h0;
      if (char_i >= 8'h30 && char_i <= 8'h39) begin
         nibble_o = char_i[3:0];
      end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                   (char_i >= 8'h61 && char_i <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 maps them to 10.
         nibble_o = char_i[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/console_cmd_parser.sv
// Parses "R ADDR<CR>" / "W ADDR DATA<CR>" console lines into bus commands.
module console_cmd_parser
   import console_pkg::*;
#(
   parameter int unsigned ADDR_DIGITS = 4,
   parameter int unsigned DATA_DIGITS = 2
) (
   input logic                  clk,
   input logic                  rst,
   console_cmd_parser_if.master bus
);

   localparam int unsigned AW = 4 * ADDR_DIGITS;
   localparam int unsigned DW = 4 * DATA_DIGITS;
   localparam int unsigned MaxDigits = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
   localparam int unsigned CW = $clog2(MaxDigits + 1);

   state_e          state_q;
   logic            write_q;
   logic [CW-1:0]   count_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic            valid_q;
   logic            error_q;
   logic            dropped_q;

   logic [3:0] nibble;
   logic       is_hex;
   logic       is_cr;
   logic       is_sp;
   logic       is_lf;
   logic       have_digit;

   ascii_to_hex u_ascii_to_hex (
      .char_i   (bus.rx_data),
      .nibble_o (nibble)
   );

   assign is_hex     = is_hex_char(bus.rx_data);
   assign is_cr      = (bus.rx_data == AsciiCr);
   assign is_sp      = (bus.rx_data == AsciiSp);
   assign is_lf      = (bus.rx_data == AsciiLf);
   assign have_digit = (count_q != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         write_q   <= 1'b0;
         count_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         error_q   <= 1'b0;
         dropped_q <= 1'b0;
         if (state_q == StPend) begin
            if (valid_q && bus.cmd_ready) begin
               valid_q <= 1'b0;
               state_q <= StIdle;
            end
            if (bus.rx_valid && !is_lf) begin
               dropped_q <= 1'b1;
            end
         end else if (bus.rx_valid && !is_lf) begin
            unique case (state_q)
               StIdle: begin
                  if (bus.rx_data == AsciiRUp || bus.rx_data == AsciiRLo) begin
                     write_q <= 1'b0;
                     state_q <= StOp;
                  end else if (bus.rx_data == AsciiWUp || bus.rx_data == AsciiWLo) begin
                     write_q <= 1'b1;
                     state_q <= StOp;
                  end else if (!is_cr) begin
                     state_q <= StSkip;
                  end
               end
               StOp: begin
                  if (is_sp) begin
                     addr_q  <= '0;
                     count_q <= '0;
                     state_q <= StAddr;
                  end else if (is_cr) begin
                     error_q <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     state_q <= StSkip;
                  end
               end
               StAddr: begin
                  if (is_hex) begin
                     if (count_q == CW'(ADDR_DIGITS)) begin
                        state_q <= StSkip;
                     end else begin
                        addr_q  <= {addr_q[AW-5:0], nibble};
                        count_q <= count_q + 1'b1;
                     end
                  end else if (is_sp && write_q && have_digit) begin
                     wdata_q <= '0;
                     count_q <= '0;
                     state_q <= StData;
                  end else if (is_cr && !write_q && have_digit) begin
                     wdata_q <= '0;
                     valid_q <= 1'b1;
                     state_q <= StPend;
                  end else if (is_cr) begin
                     error_q <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     state_q <= StSkip;
                  end
               end
               StData: begin
                  if (is_hex) begin
                     if (count_q == CW'(DATA_DIGITS)) begin
                        state_q <= StSkip;
                     end else begin
                        wdata_q <= {wdata_q[DW-5:0], nibble};
                        count_q <= count_q + 1'b1;
                     end
                  end else if (is_cr && have_digit) begin
                     valid_q <= 1'b1;
                     state_q <= StPend;
                  end else if (is_cr) begin
                     error_q <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     state_q <= StSkip;
                  end
               end
               StSkip: begin
                  if (is_cr) begin
                     error_q <= 1'b1;
                     state_q <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.cmd_valid  = valid_q;
   assign bus.cmd_write  = write_q;
   assign bus.cmd_addr   = addr_q;
   assign bus.cmd_wdata  = wdata_q;
   assign bus.cmd_error  = error_q;
   assign bus.rx_dropped = dropped_q;

endmodule

// File: tb/tb_console_cmd_parser.sv
// Directed line vectors plus hand sequences for hold, drop and reset cases.
module tb_console_cmd_parser;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;

   console_cmd_parser_if #(.ADDR_DIGITS(4), .DATA_DIGITS(2)) bus_if ();

   console_cmd_parser #(.ADDR_DIGITS(4), .DATA_DIGITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [95:0] text;
      logic        lf;
      logic        exp_valid;
      logic        exp_write;
      logic [15:0] exp_addr;
      logic [7:0]  exp_wdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Byte is sampled on the posedge between the two negedges.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus_if.rx_data  = b;
      bus_if.rx_valid = 1'b1;
      @(negedge clk);
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic send_text(input logic [95:0] text);
      logic [7:0] b;
      for (int k = 11; k >= 0; k--) begin
         b = text[8*k +: 8];
         if (b != 8'h00) send_byte(b);
      end
   endtask

   task automatic handshake(input string name);
      @(negedge clk);
      bus_if.cmd_ready = 1'b1;
      @(negedge clk);
      bus_if.cmd_ready = 1'b0;
      check({name, " valid after accept"}, 32'(bus_if.cmd_valid), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, " valid"}, 32'(bus_if.cmd_valid), 32'd0);
      check({name, " write"}, 32'(bus_if.cmd_write), 32'd0);
      check({name, " addr"}, 32'(bus_if.cmd_addr), 32'd0);
      check({name, " wdata"}, 32'(bus_if.cmd_wdata), 32'd0);
      check({name, " error"}, 32'(bus_if.cmd_error), 32'd0);
      check({name, " dropped"}, 32'(bus_if.rx_dropped), 32'd0);
   endtask

   initial begin
      string nm;
      n_vec  = 0;
      n_miss = 0;
      rst = 1'b1;
      bus_if.rx_data  = 8'h00;
      bus_if.rx_valid = 1'b0;
      bus_if.cmd_ready = 1'b0;

      vecs[0]  = '{96'("r BEEF"),    1'b1, 1'b1, 1'b0, 16'hBEEF, 8'h00, 1'b0};
      vecs[1]  = '{96'("W 12345 6"), 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[2]  = '{96'("R 7"),       1'b0, 1'b1, 1'b0, 16'h0007, 8'h00, 1'b0};
      vecs[3]  = '{96'("X 1"),       1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[4]  = '{96'("R 12 3"),    1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[5]  = '{96'("W 10"),      1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[6]  = '{96'(""),          1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0};
      vecs[7]  = '{96'("w 0000 ff"), 1'b0, 1'b1, 1'b1, 16'h0000, 8'hFF, 1'b0};
      vecs[8]  = '{96'("R a"),       1'b0, 1'b1, 1'b0, 16'h000A, 8'h00, 1'b0};
      vecs[9]  = '{96'("W 00001 1"), 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[10] = '{96'("W 1 123"),   1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[11] = '{96'("R  1"),      1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[12] = '{96'("R"),         1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[13] = '{96'("W ABCD 0"),  1'b0, 1'b1, 1'b1, 16'hABCD, 8'h00, 1'b0};
      vecs[14] = '{96'("W 1 "),      1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[15] = '{96'("RW 1"),      1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
      vecs[16] = '{96'(" R 1"),      1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Write with held-off ready: fields must not move while pending.
      send_text(96'("W 1A 5f"));
      send_byte(8'h0D);
      check("hold valid", 32'(bus_if.cmd_valid), 32'd1);
      check("hold write", 32'(bus_if.cmd_write), 32'd1);
      check("hold addr", 32'(bus_if.cmd_addr), 32'h001A);
      check("hold wdata", 32'(bus_if.cmd_wdata), 32'h5F);
      check("hold error", 32'(bus_if.cmd_error), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nm = $sformatf("hold cyc%0d", i);
         check({nm, " valid"}, 32'(bus_if.cmd_valid), 32'd1);
         check({nm, " addr"}, 32'(bus_if.cmd_addr), 32'h001A);
         check({nm, " wdata"}, 32'(bus_if.cmd_wdata), 32'h5F);
      end
      handshake("hold");

      for (int v = 0; v < 17; v++) begin
         nm = $sformatf("vec%0d", v);
         send_text(vecs[v].text);
         send_byte(8'h0D);
         check({nm, " error"}, 32'(bus_if.cmd_error), 32'(vecs[v].exp_err));
         check({nm, " valid"}, 32'(bus_if.cmd_valid), 32'(vecs[v].exp_valid));
         if (vecs[v].exp_valid) begin
            check({nm, " write"}, 32'(bus_if.cmd_write), 32'(vecs[v].exp_write));
            check({nm, " addr"}, 32'(bus_if.cmd_addr), 32'(vecs[v].exp_addr));
            check({nm, " wdata"}, 32'(bus_if.cmd_wdata), 32'(vecs[v].exp_wdata));
         end
         if (vecs[v].lf) begin
            send_byte(8'h0A);
            check({nm, " lf error"}, 32'(bus_if.cmd_error), 32'd0);
            check({nm, " lf valid"}, 32'(bus_if.cmd_valid), 32'(vecs[v].exp_valid));
            check({nm, " lf addr"}, 32'(bus_if.cmd_addr), 32'(vecs[v].exp_addr));
         end else begin
            @(negedge clk);
            check({nm, " error pulse end"}, 32'(bus_if.cmd_error), 32'd0);
         end
         if (vecs[v].exp_valid) handshake(nm);
      end

      // Byte during pending command, then byte coinciding with the handshake.
      send_text(96'("R 1"));
      send_byte(8'h0D);
      check("drop valid", 32'(bus_if.cmd_valid), 32'd1);
      send_byte(8'h52);
      check("drop pulse", 32'(bus_if.rx_dropped), 32'd1);
      check("drop valid kept", 32'(bus_if.cmd_valid), 32'd1);
      check("drop addr kept", 32'(bus_if.cmd_addr), 32'h0001);
      check("drop write kept", 32'(bus_if.cmd_write), 32'd0);
      @(negedge clk);
      check("drop pulse end", 32'(bus_if.rx_dropped), 32'd0);
      bus_if.rx_data   = 8'h72;
      bus_if.rx_valid  = 1'b1;
      bus_if.cmd_ready = 1'b1;
      @(negedge clk);
      bus_if.rx_valid  = 1'b0;
      bus_if.cmd_ready = 1'b0;
      check("hs drop pulse", 32'(bus_if.rx_dropped), 32'd1);
      check("hs drop valid", 32'(bus_if.cmd_valid), 32'd0);

      // Asynchronous reset in the middle of a write line.
      send_text(96'("W 12 "));
      check("mid addr", 32'(bus_if.cmd_addr), 32'h0012);
      check("mid write", 32'(bus_if.cmd_write), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("async rst");
      @(negedge clk);
      rst = 1'b0;
      send_text(96'("R 3"));
      send_byte(8'h0D);
      check("post rst valid", 32'(bus_if.cmd_valid), 32'd1);
      check("post rst write", 32'(bus_if.cmd_write), 32'd0);
      check("post rst addr", 32'(bus_if.cmd_addr), 32'h0003);
      check("post rst wdata", 32'(bus_if.cmd_wdata), 32'h00);
      handshake("post rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/console_cmd_parser.md
Name: console_cmd_parser

Overview:
Command sequencer for the UART console. It consumes the received ASCII byte stream and drives the ascii_to_hex nibble decoder. It accumulates hex fields and issues complete read or write commands to the console register bus over a valid/ready handshake. It sits between the UART receiver and the console bus master. Malformed lines are flagged and discarded.

Parameters:
ADDR_DIGITS, 4, maximum hex digits in the address field; cmd_addr width is 4*ADDR_DIGITS.
DATA_DIGITS, 2, maximum hex digits in the data field; cmd_wdata width is 4*DATA_DIGITS.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
rx_data  in  8  received ASCII byte.
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
cmd_valid  out  1  command pending; held until accepted.
cmd_ready  in  1  bus master accepts the command when cmd_valid && cmd_ready.
cmd_write  out  1  1 = write command, 0 = read command.
cmd_addr  out  4*ADDR_DIGITS  address field, zero-extended on the left.
cmd_wdata  out  4*DATA_DIGITS  write data; 0 for reads.
cmd_error  out  1  one-cycle pulse when a malformed line ends.
rx_dropped  out  1  one-cycle pulse when a byte arrives while a command is pending.

Behaviour:
- Decided interface: single clock clk; reset rst is asynchronous and active-high.
- Reset: state=IDLE. All outputs are 0, including cmd_addr, cmd_wdata, the digit counter and the write flag.
- A byte is processed only in a cycle with rx_valid=1. LF (0x0A) is ignored in every state.
- Hex character: 0-9, a-f or A-F. The nibble value comes from the ascii_to_hex instance.
- Grammar: "W<sp>ADDR<sp>DATA<CR>" or "R<sp>ADDR<sp>... " is not allowed; reads are "R<sp>ADDR<CR>". Opcode is case-insensitive. Exactly one 0x20 separates fields.
- States and transitions:
  - IDLE: 'R'/'r' -> OP with write=0. 'W'/'w' -> OP with write=1. CR -> IDLE, blank line, no error. Any other byte -> SKIP.
  - OP: space -> ADDR; clears the address accumulator and the digit count. Any other byte -> SKIP. CR -> cmd_error pulse, then IDLE.
  - ADDR: on a hex digit, addr <= {addr[4*ADDR_DIGITS-5:0], nibble} and the count increments. A digit beyond ADDR_DIGITS -> SKIP.
    - Space with write=1 and count>=1 -> DATA; clears the data accumulator and the count.
    - CR with write=0 and count>=1 -> PEND.
    - Any other byte or combination -> SKIP. If that byte is CR, pulse cmd_error instead and go to IDLE.
  - DATA: hex digit handling is the same, bounded by DATA_DIGITS. CR with count>=1 -> PEND. Any other byte -> SKIP, or the CR error path.
  - SKIP: discard bytes until CR. On CR, cmd_error=1 in the next cycle and state -> IDLE.
  - PEND: cmd_valid=1 with fields stable. When cmd_valid && cmd_ready, cmd_valid=0 in the next cycle and state -> IDLE.
    - rx_valid in PEND drops the byte and pulses rx_dropped the next cycle.
    - If rx_valid and the handshake occur in the same cycle, the byte is dropped and rx_dropped pulses.
- Latency: cmd_valid rises on the cycle after the terminating CR is sampled. cmd_error also rises one cycle after CR and lasts exactly 1 cycle.
- cmd_wdata is forced to 0 when entering PEND from a read.
- Reset mid-line or mid-PEND: immediate return to reset values. A pending command is lost.
- Leading zeros count toward the digit limit.

Decomposition:
- Shared package console_pkg:
  - state enum encoding;
  - ASCII constants: CR 0x0D, LF 0x0A, SP 0x20, 'R', 'r', 'W', 'w';
  - function is_hex_char(byte).
- Sub-module: one ascii_to_hex instance fed by rx_data, combinational nibble output. No other sub-modules.

Test Plan:
- "W 1A 5f\r" -> one cycle after CR: cmd_valid=1, cmd_write=1, cmd_addr=0x001A, cmd_wdata=0x5F. Hold cmd_ready=0 for 3 cycles: outputs are stable. Then cmd_ready=1 -> cmd_valid=0 next cycle.
- "r BEEF\r\n" -> cmd_write=0, cmd_addr=0xBEEF, cmd_wdata=0x00. The LF is ignored and no error occurs.
- "W 12345 6\r" (5 address digits) -> no cmd_valid; a single cmd_error pulse one cycle after CR. A following "R 7\r" gives cmd_addr=0x0007.
- Malformed lines "X 1\r", "R 12 3\r", "W 10\r" and "\r" -> cmd_error pulses for the first three only; the blank line gives no pulse and no command.
- While pending from "R 1\r", send 'R' with cmd_ready=0 -> rx_dropped pulse and the command fields are unchanged. Also drive rx_valid in the same cycle as the handshake -> rx_dropped pulses.
- Assert rst after "W 12 " mid-line -> all outputs 0 asynchronously. Then "R 3\r" -> cmd_addr=0x0003, cmd_write=0.
